// File: rtl/mul_cascade_pkg.sv
// Shared constants and helpers for the cascaded shift-add multiplier.
package mul_cascade_pkg;

    localparam int MUL_N_DEFAULT = 23;

    // Edges from operand capture to the product appearing on z.
    function automatic int mul_latency(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/mul_cascade_row.sv
// One registered shift-add row: adds x shifted by ROW-1 when multiplier bit ROW-1 is set.
module mul_cascade_row
    import mul_cascade_pkg::*;
#(
    parameter int N   = MUL_N_DEFAULT,
    parameter int ROW = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   x_in,
    input  logic [N-1:0]   y_in,
    input  logic [2*N-1:0] acc_in,
    output logic [N-1:0]   x_out,
    output logic [N-1:0]   y_out,
    output logic [2*N-1:0] acc_out
);

    logic [2*N-1:0] partial;

    always_comb begin
        partial = '0;
        if (y_in[ROW-1]) begin
            partial = {{N{1'b0}}, x_in} << (ROW - 1);
        end
    end

    // The accumulator is 2N bits wide, so the running sum never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out   <= '0;
            y_out   <= '0;
            acc_out <= '0;
        end else begin
            x_out   <= x_in;
            y_out   <= y_in;
            acc_out <= acc_in + partial;
        end
    end

endmodule

// File: rtl/mul_cascade.sv
// Fully pipelined unsigned N x N -> 2N multiplier: input register followed by N shift-add rows.
module mul_cascade
    import mul_cascade_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] z
);

    logic [N-1:0]   x_pipe   [0:N];
    logic [N-1:0]   y_pipe   [0:N];
    logic [2*N-1:0] acc_pipe [0:N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_pipe[0] <= '0;
            y_pipe[0] <= '0;
        end else begin
            x_pipe[0] <= x;
            y_pipe[0] <= y;
        end
    end

    assign acc_pipe[0] = '0;

    // Row i consumes multiplier bit i-1; the operands travel alongside their partial sum.
    for (genvar i = 1; i <= N; i++) begin : g_row
        mul_cascade_row #(
            .N   (N),
            .ROW (i)
        ) u_row (
            .clk     (clk),
            .rst     (rst),
            .x_in    (x_pipe[i-1]),
            .y_in    (y_pipe[i-1]),
            .acc_in  (acc_pipe[i-1]),
            .x_out   (x_pipe[i]),
            .y_out   (y_pipe[i]),
            .acc_out (acc_pipe[i])
        );
    end

    assign z = acc_pipe[N];

endmodule

// File: tb/tb_mul_cascade.sv
// Scoreboard bench for mul_cascade at N=23 and N=4 with directed, random and exhaustive vectors.
module tb_mul_cascade;
    import mul_cascade_pkg::*;

    localparam int LAT23 = mul_latency(23);
    localparam int LAT4  = mul_latency(4);

    typedef struct {
        logic [45:0] exp;
        int          due;
        string       tag;
    } sb_item_t;

    logic        clk;
    logic        rst;
    logic [22:0] x23, y23;
    logic [45:0] z23;
    logic [3:0]  x4, y4;
    logic [7:0]  z4;

    int cycle;
    int compared;
    int mismatched;

    sb_item_t sb23[$];
    sb_item_t sb4[$];

    mul_cascade #(.N(23)) dut23 (
        .clk (clk),
        .rst (rst),
        .x   (x23),
        .y   (y23),
        .z   (z23)
    );

    mul_cascade #(.N(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .x   (x4),
        .y   (y4),
        .z   (z4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [45:0] actual, input logic [45:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    // Drive one operand pair for capture on the next rising edge and book its product.
    task automatic applyStimulus(input logic [22:0] xv, input logic [22:0] yv,
                                 input logic [45:0] exp, input string tag);
        sb_item_t item;
        @(negedge clk);
        x23 = xv;
        y23 = yv;
        item.exp = exp;
        item.due = cycle + LAT23;
        item.tag = tag;
        sb23.push_back(item);
    endtask

    task automatic applyStimulusSmall(input logic [3:0] xv, input logic [3:0] yv,
                                      input logic [7:0] exp, input string tag);
        sb_item_t item;
        @(negedge clk);
        x4 = xv;
        y4 = yv;
        item.exp = {38'd0, exp};
        item.due = cycle + LAT4;
        item.tag = tag;
        sb4.push_back(item);
    endtask

    // Monitors: z is due exactly one latency after each booked capture.
    always @(negedge clk) begin
        sb_item_t item;
        while (sb23.size() > 0 && sb23[0].due < cycle) begin
            item = sb23.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: result never observed, expected 0x%0h", item.tag, item.exp);
        end
        if (sb23.size() > 0 && sb23[0].due == cycle) begin
            item = sb23.pop_front();
            checkOutput(item.tag, z23, item.exp);
        end
    end

    always @(negedge clk) begin
        sb_item_t item;
        while (sb4.size() > 0 && sb4[0].due < cycle) begin
            item = sb4.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: result never observed, expected 0x%0h", item.tag, item.exp);
        end
        if (sb4.size() > 0 && sb4[0].due == cycle) begin
            item = sb4.pop_front();
            checkOutput(item.tag, {38'd0, z4}, item.exp);
        end
    end

    task automatic pulseReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb23.delete();
        sb4.delete();
        #1;
        checkOutput("async_reset_z23", z23, 46'd0);
        checkOutput("async_reset_z4", {38'd0, z4}, 46'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [22:0] rx, ry;
        cycle      = 0;
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        x23 = '0;
        y23 = '0;
        x4  = '0;
        y4  = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_z23", z23, 46'd0);
        checkOutput("reset_z4", {38'd0, z4}, 46'd0);
        #1;
        rst = 1'b0;

        applyStimulus(23'd1, 23'd1, 46'd1, "identity");
        applyStimulus(23'd0, 23'h7FFFFF, 46'd0, "zero_x");
        applyStimulus(23'h7FFFFF, 23'h7FFFFF, 46'h3FFFFF000001, "max_max");
        applyStimulus(23'h400000, 23'd2, 46'h800000, "msb_times_two");
        applyStimulus(23'h7FFFFF, 23'd0, 46'd0, "zero_y");
        applyStimulus(23'h123456, 23'd16, 46'h1234560, "shift_by_16");

        for (int k = 1; k <= 30; k++) begin
            applyStimulus(23'(k), 23'(k + 1), 46'(k * (k + 1)), "stream_k");
        end

        // Keep large products in flight so the asynchronous clear is visible on z.
        for (int k = 0; k < 26; k++) begin
            applyStimulus(23'h7FFFFF, 23'h7FFFFF, 46'h3FFFFF000001, "prereset_max");
        end
        pulseReset();
        for (int k = 0; k < 28; k++) begin
            applyStimulus(23'd0, 23'd0, 46'd0, "post_reset_zero");
        end

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            x23 = 23'($urandom());
            y23 = 23'($urandom());
        end
        pulseReset();
        for (int k = 0; k < 28; k++) begin
            applyStimulus(23'd0, 23'd0, 46'd0, "flush_zero");
        end

        for (int k = 0; k < 1000; k++) begin
            rx = 23'($urandom());
            ry = 23'($urandom());
            applyStimulus(rx, ry, {23'd0, rx} * {23'd0, ry}, "random23");
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulusSmall(4'(a), 4'(b), 8'(a * b), "exhaustive4");
            end
        end

        repeat (LAT23 + 4) @(posedge clk);
        #1;
        compared++;
        if (sb23.size() != 0 || sb4.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d/%0d results still pending, expected 0", sb23.size(), sb4.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
